// File: rtl/typing_pkg.sv
// Shared types and defaults for the typing-game letter scheduler.
package typing_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_KEY,
    S_RESOLVE
  } state_t;

  typedef struct packed {
    logic       active;
    logic [7:0] ch;
    logic [3:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } slot_t;

  localparam logic [8:0] X_MAX_DEF     = 9'd470;
  localparam int         SPAWN_GAP_DEF = 32;
  localparam logic [7:0] ASCII_A       = 8'h61;

endpackage

// File: rtl/letter_slot_file.sv
// Letter slot register array: one write port, renderer and scan read ports,
// and a lowest-free-slot priority encoder.
module letter_slot_file
  import typing_pkg::*;
#(
  parameter  int SLOTS = 8,
  localparam int IW    = $clog2(SLOTS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [IW-1:0] i_w_idx,
  input  slot_t         i_w_data,
  input  logic [IW-1:0] i_rd_idx,
  output slot_t         o_rd_slot,
  input  logic [IW-1:0] i_sc_idx,
  output slot_t         o_sc_slot,
  output logic          o_free_any,
  output logic [IW-1:0] o_free_idx
);

  slot_t r_slots [SLOTS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SLOTS; i++) r_slots[i] <= '0;
    end else if (i_we) begin
      r_slots[i_w_idx] <= i_w_data;
    end
  end

  assign o_rd_slot = r_slots[i_rd_idx];
  assign o_sc_slot = r_slots[i_sc_idx];

  // Scan downward so the lowest free index is the one left standing.
  always_comb begin
    o_free_any = 1'b0;
    o_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_slots[i].active) begin
        o_free_any = 1'b1;
        o_free_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/letter_scheduler.sv
// Falling-letter slot scheduler: per-frame move/retire/spawn and keystroke
// hit resolution over a shared slot file.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | accept keystroke, or take a pending frame (frame wins)
//  S_MOVE    | advance slot r_idx by its speed, retire at X_MAX as a miss
//  S_SPAWN   | on gap expiry, load generator letter into lowest free slot
//  S_KEY     | scan slot r_idx for the lowest (largest x) matching letter
//  S_RESOLVE | clear the best match (hit) or flag a wrong key
module letter_scheduler
  import typing_pkg::*;
#(
  parameter  int         SLOTS     = 8,
  parameter  int         SPAWN_GAP = SPAWN_GAP_DEF,
  parameter  logic [8:0] X_MAX     = X_MAX_DEF,
  localparam int         IW        = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic [7:0]    gen_ch,
  input  logic [3:0]    gen_speed,
  input  logic [8:0]    gen_x,
  input  logic [9:0]    gen_y,
  input  logic          key_valid,
  input  logic [7:0]    key_ch,
  output logic          key_ready,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_active,
  output logic [7:0]    rd_ch,
  output logic [8:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic          hit,
  output logic          wrong,
  output logic          miss,
  output logic [IW:0]   active_cnt
);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_pending;
  logic [7:0]    r_gap;
  logic [7:0]    r_key_ch;
  logic          r_best_vld;
  logic [IW-1:0] r_best_idx;
  logic [8:0]    r_best_x;
  logic [IW:0]   r_active_cnt;

  slot_t         w_scan;
  slot_t         w_rd;
  slot_t         w_wdata;
  logic          w_we;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_sc_idx;
  logic          w_free_any;
  logic [IW-1:0] w_free_idx;
  logic [9:0]    w_nx;
  logic          w_retire;
  logic          w_cand;
  logic          w_last;
  logic          w_gap_due;
  logic          w_spawn;
  logic          w_clear;

  letter_slot_file #(.SLOTS(SLOTS)) u_slots (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_we       (w_we),
    .i_w_idx    (w_widx),
    .i_w_data   (w_wdata),
    .i_rd_idx   (rd_idx),
    .o_rd_slot  (w_rd),
    .i_sc_idx   (w_sc_idx),
    .o_sc_slot  (w_scan),
    .o_free_any (w_free_any),
    .o_free_idx (w_free_idx)
  );

  // RESOLVE reads back the winning slot so it can be rewritten inactive.
  assign w_sc_idx  = (r_state == S_RESOLVE) ? r_best_idx : r_idx;
  assign w_last    = (r_idx == IW'(SLOTS - 1));
  assign w_nx      = {1'b0, w_scan.x} + {6'd0, w_scan.speed};
  assign w_retire  = (r_state == S_MOVE) && w_scan.active && (w_nx >= {1'b0, X_MAX});
  assign w_cand    = w_scan.active && (w_scan.ch == r_key_ch);
  assign w_gap_due = (r_gap >= 8'(SPAWN_GAP));
  assign w_spawn   = (r_state == S_SPAWN) && w_gap_due && w_free_any;
  assign w_clear   = (r_state == S_RESOLVE) && r_best_vld;

  always_comb begin
    w_we    = 1'b0;
    w_widx  = r_idx;
    w_wdata = w_scan;
    case (r_state)
      S_MOVE: begin
        if (w_scan.active) begin
          w_we = 1'b1;
          if (w_retire) w_wdata.active = 1'b0;
          else          w_wdata.x      = w_nx[8:0];
        end
      end
      S_SPAWN: begin
        if (w_spawn) begin
          w_we    = 1'b1;
          w_widx  = w_free_idx;
          w_wdata = {1'b1, gen_ch, gen_speed, gen_x, gen_y};
        end
      end
      S_RESOLVE: begin
        if (r_best_vld) begin
          w_we           = 1'b1;
          w_widx         = r_best_idx;
          w_wdata.active = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_gap        <= '0;
      r_key_ch     <= '0;
      r_best_vld   <= 1'b0;
      r_best_idx   <= '0;
      r_best_x     <= '0;
      r_active_cnt <= '0;
    end else begin
      if (w_spawn)
        r_active_cnt <= r_active_cnt + (IW + 1)'(1);
      else if (w_retire || w_clear)
        r_active_cnt <= r_active_cnt - (IW + 1)'(1);

      if (frame_tick)
        r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_pending <= frame_tick;
            r_idx     <= '0;
            r_state   <= S_MOVE;
          end else if (key_valid) begin
            r_key_ch   <= key_ch;
            r_best_vld <= 1'b0;
            r_idx      <= '0;
            r_state    <= S_KEY;
          end
        end
        S_MOVE: begin
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_gap   <= r_gap + 8'd1;
            r_state <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (w_gap_due) r_gap <= '0;
          r_state <= S_IDLE;
        end
        S_KEY: begin
          // Strict compare keeps the lower index on equal rows.
          if (w_cand && (!r_best_vld || (w_scan.x > r_best_x))) begin
            r_best_vld <= 1'b1;
            r_best_idx <= r_idx;
            r_best_x   <= w_scan.x;
          end
          r_idx <= r_idx + IW'(1);
          if (w_last) r_state <= S_RESOLVE;
        end
        S_RESOLVE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready  = rst_n && (r_state == S_IDLE) && !r_pending;
  assign hit        = (r_state == S_RESOLVE) && r_best_vld;
  assign wrong      = (r_state == S_RESOLVE) && !r_best_vld;
  assign miss       = w_retire;
  assign active_cnt = r_active_cnt;

  assign rd_active = w_rd.active;
  assign rd_ch     = w_rd.ch;
  assign rd_x      = w_rd.x;
  assign rd_y      = w_rd.y;

endmodule

// File: tb/tb_letter_scheduler.sv
// Directed bench for letter_scheduler with hand-computed expectations.
module tb_letter_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] gen_ch = 8'h61;
  logic [3:0] gen_speed = 4'd1;
  logic [8:0] gen_x = 9'd0;
  logic [9:0] gen_y = 10'd0;
  logic       key_valid = 1'b0;
  logic [7:0] key_ch = 8'h00;
  logic       key_ready;
  logic [2:0] rd_idx = 3'd0;
  logic       rd_active;
  logic [7:0] rd_ch;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic       hit, wrong, miss;
  logic [3:0] active_cnt;

  int n_vec = 0;
  int n_err = 0;
  int f_miss, f_first, f_sum;
  int k_hit, k_hit_j, k_wrong, k_wrong_j;
  logic [31:0] hit_map, rdy_map;

  letter_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .gen_ch     (gen_ch),
    .gen_speed  (gen_speed),
    .gen_x      (gen_x),
    .gen_y      (gen_y),
    .key_valid  (key_valid),
    .key_ch     (key_ch),
    .key_ready  (key_ready),
    .rd_idx     (rd_idx),
    .rd_active  (rd_active),
    .rd_ch      (rd_ch),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .hit        (hit),
    .wrong      (wrong),
    .miss       (miss),
    .active_cnt (active_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input int i);
    rd_idx = 3'(i);
    #1;
  endtask

  // Sample s=0 is the IDLE cycle taking the frame; s=1..8 are MOVE idx 0..7.
  task automatic run_frame;
    f_miss  = 0;
    f_first = -1;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (s == 0) frame_tick = 1'b0;
      if (miss) begin
        if (f_first < 0) f_first = s;
        f_miss++;
      end
    end
  endtask

  task automatic frames(input int n);
    f_sum = 0;
    for (int i = 0; i < n; i++) begin
      run_frame();
      f_sum += f_miss;
    end
  endtask

  // j=0 is the accept cycle; RESOLVE is expected at j=9.
  task automatic press(input logic [7:0] ch);
    k_hit = 0; k_hit_j = -1; k_wrong = 0; k_wrong_j = -1;
    @(negedge clk);
    key_ch    = ch;
    key_valid = 1'b1;
    #1;
    check("key_ready_accept", key_ready, 1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) key_valid = 1'b0;
      if (hit)   begin if (k_hit_j < 0)   k_hit_j = j;   k_hit++;   end
      if (wrong) begin if (k_wrong_j < 0) k_wrong_j = j; k_wrong++; end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_active_cnt", active_cnt, 0);
    check("rst_key_ready", key_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_key_ready", key_ready, 1);
  endtask

  task automatic spawn(input logic [7:0] ch, input logic [8:0] x, input logic [9:0] y);
    gen_ch = ch;
    gen_x  = x;
    gen_y  = y;
    frames(32);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_key_ready_low", key_ready, 0);
    rst_n = 1'b1;
    #1;
    check("reset_key_ready", key_ready, 1);
    check("reset_flags", {29'd0, hit, wrong, miss}, 0);
    check("reset_active_cnt", active_cnt, 0);
    peek(0);
    check("reset_slot0", {rd_active, rd_ch, rd_x, rd_y}, 0);

    // First spawn on the 32nd frame
    gen_ch = 8'h61; gen_speed = 4'd1; gen_x = 9'd0; gen_y = 10'd90;
    frames(31);
    check("no_spawn_before_gap", active_cnt, 0);
    run_frame();
    peek(0);
    check("spawn_active", rd_active, 1);
    check("spawn_ch", rd_ch, 8'h61);
    check("spawn_x", rd_x, 0);
    check("spawn_y", rd_y, 90);
    check("spawn_cnt", active_cnt, 1);
    peek(1);
    check("spawn_slot1_free", rd_active, 0);

    // Retire at X_MAX
    do_reset();
    gen_speed = 4'd2;
    spawn(8'h6d, 9'd468, 10'd5);
    peek(0);
    check("pre_miss_x", rd_x, 468);
    run_frame();
    check("miss_count", f_miss, 1);
    check("miss_cycle", f_first, 1);
    peek(0);
    check("miss_slot_cleared", rd_active, 0);
    check("miss_cnt", active_cnt, 0);
    gen_x = 9'd467;
    frames(31);
    peek(0);
    check("respawn_x", rd_x, 467);
    run_frame();
    check("no_miss_469", f_miss, 0);
    peek(0);
    check("moved_469", rd_x, 469);
    run_frame();
    check("miss_471", f_miss, 1);
    check("miss_471_cnt", active_cnt, 0);

    // Hit selection: largest x wins, ties go to the lower index
    do_reset();
    gen_speed = 4'd0;
    spawn(8'h61, 9'd50, 10'd10);
    spawn(8'h63, 9'd100, 10'd20);
    spawn(8'h62, 9'd150, 10'd30);
    spawn(8'h63, 9'd200, 10'd40);
    check("four_cnt", active_cnt, 4);
    press(8'h63);
    check("hit_c_count", k_hit, 1);
    check("hit_c_cycle", k_hit_j, 9);
    check("hit_c_no_wrong", k_wrong, 0);
    peek(3);
    check("hit_c_slot3", rd_active, 0);
    peek(1);
    check("hit_c_slot1", {rd_active, rd_x}, {1'b1, 9'd100});
    check("hit_c_cnt", active_cnt, 3);

    press(8'h7a);
    check("wrong_count", k_wrong, 1);
    check("wrong_cycle", k_wrong_j, 9);
    check("wrong_no_hit", k_hit, 0);
    check("wrong_cnt", active_cnt, 3);
    peek(1);
    check("wrong_slot1", {rd_active, rd_ch}, {1'b1, 8'h63});

    press(8'h63);
    peek(1);
    check("hit_c2_slot1", rd_active, 0);
    check("hit_c2_cnt", active_cnt, 2);
    spawn(8'h63, 9'd200, 10'd50);
    spawn(8'h63, 9'd200, 10'd60);
    peek(1);
    check("tie_slot1_loaded", {rd_active, rd_x, rd_y}, {1'b1, 9'd200, 10'd50});
    press(8'h63);
    check("tie_hit", k_hit, 1);
    peek(1);
    check("tie_slot1_cleared", rd_active, 0);
    peek(3);
    check("tie_slot3_kept", rd_active, 1);
    check("tie_cnt", active_cnt, 3);

    // Frame during KEY, second key held through frame service
    hit_map = '0;
    rdy_map = '0;
    @(negedge clk);
    key_ch    = 8'h62;
    key_valid = 1'b1;
    for (int j = 1; j < 32; j++) begin
      @(negedge clk);
      #1;
      hit_map[j] = hit;
      rdy_map[j] = key_ready;
      if (j == 1)  key_ch = 8'h61;
      if (j == 3)  frame_tick = 1'b1;
      if (j == 4)  frame_tick = 1'b0;
      if (j == 21) key_valid = 1'b0;
    end
    check("busy_hit_map", hit_map, 32'h2000_0200);
    check("busy_ready_map", rdy_map, 32'hC010_0000);
    peek(0);
    check("busy_slot0", rd_active, 0);
    peek(2);
    check("busy_slot2", rd_active, 0);
    check("busy_cnt", active_cnt, 1);

    // Full slot file: spawn dropped, gap counter still restarts
    do_reset();
    gen_speed = 4'd0;
    for (int i = 0; i < 8; i++) spawn(8'h64 + 8'(i), 9'(10 * i), 10'(i));
    check("full_cnt", active_cnt, 8);
    spawn(8'h71, 9'd300, 10'd300);
    check("full_drop_cnt", active_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      peek(i);
      check("full_no_overwrite", {rd_active, rd_ch}, {1'b1, 8'h64 + 8'(i)});
    end
    press(8'h64);
    check("full_free_cnt", active_cnt, 7);
    frames(31);
    check("gap_restart_31", active_cnt, 7);
    run_frame();
    check("gap_restart_32", active_cnt, 8);
    peek(0);
    check("refill_slot0", rd_ch, 8'h71);

    // Asynchronous reset in the middle of a MOVE scan
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmove_cnt", active_cnt, 0);
    check("midmove_flags", {28'd0, key_ready, hit, wrong, miss}, 0);
    peek(0);
    check("midmove_slot0", {rd_active, rd_ch, rd_x, rd_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midmove_release_ready", key_ready, 1);
    peek(7);
    check("midmove_slot7", rd_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
